serial_tx_piso: RTL and testbench
=================================

// Module: serial_tx_piso
// PURPOSE
//  Parallel-in/serial-out frame transmitter: captures a DATA_WIDTH word on a valid/ready
//  handshake and shifts it onto a single line as start bit, data LSB-first, stop bit.
//  Transmit end of the team's serial link; the receive side samples TxOut into D flip-flops.
//  Sits between the datapath (word producer) and the board-level serial pin.
// PARAMETERS
//  DATA_WIDTH    8  data bits per frame, >= 1
//  CLKS_PER_BIT  4  Clk cycles each line bit is held, >= 1 (1 must work)
// PORTS
//  Clk     in   1           clock, all state updates on rising edge
//  Reset   in   1           reset, asynchronous, active-high
//  Data    in   DATA_WIDTH  word to send; sampled only on accept
//  Valid   in   1           producer has a word on Data
//  Ready   out  1           transmitter idle, can accept a word
//  TxOut   out  1           serial line, idle/stop = 1, start = 0
//  Busy    out  1           frame in progress (START, DATA or STOP state)
//  Done    out  1           one-cycle pulse, last cycle of the stop bit
// BEHAVIOUR
//  Reset (async, immediate, any state): state=IDLE, TxOut=1, Ready=1, Busy=0, Done=0,
//   shift reg/counters=0. Reset mid-frame aborts the frame; line returns high at once.
//  FSM states: IDLE, START, DATA, STOP. All outputs registered or decoded from state only.
//  IDLE: Ready=1, TxOut=1. Accept = Valid & Ready at rising edge -> capture Data into
//   shift reg, baud counter=0, go START. Valid without Ready is ignored (no queuing).
//  START: TxOut=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
//  DATA: TxOut=shift_reg[0]; every CLKS_PER_BIT cycles shift right and increment bit
//   index; after bit DATA_WIDTH-1 completes, go STOP.
//  STOP: TxOut=1 for CLKS_PER_BIT cycles; Done=1 on its final cycle; then IDLE.
//  Latency: TxOut falls the cycle after accept. Frame length exactly
//   (DATA_WIDTH+2)*CLKS_PER_BIT cycles; Ready rises the cycle after Done.
//  Back-to-back: Valid held high gives next accept the first cycle Ready=1, i.e. one
//   idle-high cycle between frames (stop bit + 1 cycle).
//  Data changes after accept have no effect on the frame in flight.
//  Baud counter wraps CLKS_PER_BIT-1 -> 0; width $clog2(CLKS_PER_BIT) (min 1 bit).
//  Bit index width $clog2(DATA_WIDTH) (min 1 bit); never exceeds DATA_WIDTH-1.
//  Busy = ~Ready at all times; Ready and Done never both 1.
// TESTING
//  1 Reset asserted at t0, no clock -> TxOut=1, Ready=1, Busy=0, Done=0 immediately.
//  2 Defaults, Data=8'hA5, Valid 1 cycle -> TxOut sequence per 4 cycles:
//    0,1,0,1,0,0,1,0,1,1; Done pulse on cycle 40; Ready=1 on cycle 41.
//  3 Valid held, Data=8'h00 then 8'hFF -> two frames, exactly 1 idle-high cycle between,
//    second frame bits all 1, first frame data bits all 0.
//  4 Accept 8'h3C, change Data to 8'hFF the next cycle -> transmitted bits still 8'h3C.
//  5 Reset asserted during DATA bit 3 -> TxOut=1, Ready=1 same instant; after release,
//    new accept of 8'h81 sends a clean full frame.
//  6 CLKS_PER_BIT=1, DATA_WIDTH=4, Data=4'b0110 -> TxOut 0,0,1,1,0,1 on consecutive
//    cycles, Done on cycle 6; Valid while Busy=1 ignored (no extra frame).

Source files
------------

// File: rtl/serial_tx_piso.sv
// Parallel-in/serial-out frame transmitter.
// Frame: start bit (0), data LSB-first, stop bit (1).
module serial_tx_piso #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] Data,
  input  logic                  Valid,
  output logic                  Ready,
  output logic                  TxOut,
  output logic                  Busy,
  output logic                  Done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PEN  =
    CW'((CLKS_PER_BIT > 1) ? CLKS_PER_BIT - 2 : 0);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);
  localparam logic          ONE_CLK  = (CLKS_PER_BIT == 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shnext;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic                  cnt_end;

  always_comb begin
    shnext  = shreg >> 1;
    cnt_end = (cnt == CNT_LAST);
  end

  assign Busy = ~Ready;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      idx   <= '0;
      TxOut <= 1'b1;
      Ready <= 1'b1;
      Done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Valid) begin
            state <= START;
            shreg <= Data;
            cnt   <= '0;
            TxOut <= 1'b0;
            Ready <= 1'b0;
          end
        end
        START: begin
          if (cnt_end) begin
            state <= DATA;
            cnt   <= '0;
            idx   <= '0;
            TxOut <= shreg[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt_end) begin
            cnt   <= '0;
            shreg <= shnext;
            if (idx == IDX_LAST) begin
              state <= STOP;
              TxOut <= 1'b1;
              // a one-cycle stop bit is its own last cycle
              Done  <= ONE_CLK;
            end else begin
              idx   <= idx + 1'b1;
              TxOut <= shnext[0];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt_end) begin
            state <= IDLE;
            cnt   <= '0;
            Done  <= 1'b0;
            Ready <= 1'b1;
          end else begin
            cnt  <= cnt + 1'b1;
            Done <= (cnt == CNT_PEN);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_piso.sv
// Scoreboard bench for serial_tx_piso.
// Two instances: 8b/4clk and 4b/1clk.
module tb_serial_tx_piso;

  localparam int LEN_A = 40;
  localparam int LEN_B = 6;

  logic       Clk;
  logic       Reset;
  logic [7:0] data_a;
  logic       valid_a, ready_a, tx_a, busy_a, done_a;
  logic [3:0] data_b;
  logic       valid_b, ready_b, tx_b, busy_b, done_b;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int frames_a = 0;
  int frames_b = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  int starts_a[$];

  serial_tx_piso #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut_a (
    .Clk(Clk), .Reset(Reset), .Data(data_a), .Valid(valid_a),
    .Ready(ready_a), .TxOut(tx_a), .Busy(busy_a), .Done(done_a)
  );

  serial_tx_piso #(.DATA_WIDTH(4), .CLKS_PER_BIT(1)) dut_b (
    .Clk(Clk), .Reset(Reset), .Data(data_b), .Valid(valid_b),
    .Ready(ready_b), .TxOut(tx_b), .Busy(busy_b), .Done(done_b)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Returns {bad, data}: start/stop levels and per-bit constancy.
  function automatic logic [8:0] dec(input logic [63:0] tr,
                                     input int dw, input int cpb);
    logic       bad;
    logic [7:0] d;
    logic       v;
    bad = 1'b0;
    d = '0;
    for (int b = 0; b < dw + 2; b++) begin
      for (int k = 0; k < cpb; k++) begin
        v = tr[b*cpb+k];
        if (b == 0) begin
          if (v !== 1'b0) bad = 1'b1;
        end else if (b == dw + 1) begin
          if (v !== 1'b1) bad = 1'b1;
        end else if (k == 0) begin
          d[b-1] = v;
        end else if (v !== d[b-1]) begin
          bad = 1'b1;
        end
      end
    end
    return {bad, d};
  endfunction

  initial begin : mon_a
    logic [63:0] tr;
    logic        ok, abort;
    logic [8:0]  r;
    forever begin
      @(negedge Clk);
      if (!Reset && busy_a) begin
        starts_a.push_back(cyc);
        ok = 1'b1;
        abort = 1'b0;
        tr = '0;
        for (int c = 0; c < LEN_A; c++) begin
          if (c > 0) @(negedge Clk);
          if (Reset) begin
            abort = 1'b1;
            break;
          end
          tr[c] = tx_a;
          if (done_a !== (c == LEN_A - 1) || ready_a !== 1'b0 ||
              busy_a !== 1'b1) ok = 1'b0;
        end
        if (!abort) begin
          @(negedge Clk);
          chk("a_frame_done_busy", 32'(ok), 32'd1);
          chk("a_idle_after", {ready_a, busy_a, done_a, tx_a}, 4'b1001);
          r = dec(tr, 8, 4);
          if (exp_a.size() == 0) begin
            chk("a_unexpected_frame", 32'(r), 32'h1ff);
          end else begin
            chk("a_frame_data", 32'(r), {24'd0, 1'b0, exp_a.pop_front()});
          end
          frames_a++;
        end
      end
    end
  end

  initial begin : mon_b
    logic [63:0] tr;
    logic        ok, abort;
    logic [8:0]  r;
    forever begin
      @(negedge Clk);
      if (!Reset && busy_b) begin
        ok = 1'b1;
        abort = 1'b0;
        tr = '0;
        for (int c = 0; c < LEN_B; c++) begin
          if (c > 0) @(negedge Clk);
          if (Reset) begin
            abort = 1'b1;
            break;
          end
          tr[c] = tx_b;
          if (done_b !== (c == LEN_B - 1) || ready_b !== 1'b0 ||
              busy_b !== 1'b1) ok = 1'b0;
        end
        if (!abort) begin
          @(negedge Clk);
          chk("b_frame_done_busy", 32'(ok), 32'd1);
          chk("b_idle_after", {ready_b, busy_b, done_b, tx_b}, 4'b1001);
          r = dec(tr, 4, 1);
          if (exp_b.size() == 0) begin
            chk("b_unexpected_frame", 32'(r), 32'h1ff);
          end else begin
            chk("b_frame_data", 32'(r), {24'd0, 1'b0, exp_b.pop_front()});
          end
          frames_b++;
        end
      end
    end
  end

  task automatic send_a(input logic [7:0] d, input bit push);
    @(negedge Clk);
    data_a = d;
    valid_a = 1'b1;
    if (push) exp_a.push_back(d);
    @(posedge Clk);
    #1;
    valid_a = 1'b0;
    chk("a_latency_txout", 32'(tx_a), 32'd0);
  endtask

  task automatic wait_a();
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge Clk);
      if (exp_a.size() == 0) break;
    end
    chk("a_drain_timeout", 32'(exp_a.size()), 32'd0);
    @(negedge Clk);
  endtask

  initial begin
    int n0;
    Reset = 1'b1;
    data_a = '0;
    valid_a = 1'b0;
    data_b = '0;
    valid_b = 1'b0;
    #1;
    chk("reset_a_outs", {tx_a, ready_a, busy_a, done_a}, 4'b1100);
    chk("reset_b_outs", {tx_b, ready_b, busy_b, done_b}, 4'b1100);
    @(negedge Clk);
    Reset = 1'b0;

    // single frame, 8'hA5
    send_a(8'hA5, 1'b1);
    wait_a();

    // back-to-back with Valid held
    n0 = starts_a.size();
    @(negedge Clk);
    data_a = 8'h00;
    valid_a = 1'b1;
    exp_a.push_back(8'h00);
    exp_a.push_back(8'hFF);
    @(posedge Clk);
    #1;
    data_a = 8'hFF;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (ready_a) break;
    end
    chk("b2b_ready_seen", 32'(ready_a), 32'd1);
    chk("b2b_gap_line_high", 32'(tx_a), 32'd1);
    @(posedge Clk);
    #1;
    valid_a = 1'b0;
    wait_a();
    if (starts_a.size() >= n0 + 2)
      chk("b2b_start_spacing", 32'(starts_a[n0+1] - starts_a[n0]), 32'd41);
    else
      chk("b2b_frame_count", 32'(starts_a.size() - n0), 32'd2);

    // data changes after accept
    send_a(8'h3C, 1'b1);
    data_a = 8'hFF;
    wait_a();

    // reset during data bit 3
    send_a(8'h55, 1'b0);
    repeat (18) @(posedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    chk("abort_outs", {tx_a, ready_a, busy_a, done_a}, 4'b1100);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    send_a(8'h81, 1'b1);
    wait_a();

    // 4-bit, one clock per bit; Valid during Busy ignored
    @(negedge Clk);
    data_b = 4'b0110;
    valid_b = 1'b1;
    exp_b.push_back(8'h06);
    @(posedge Clk);
    #1;
    valid_b = 1'b0;
    chk("b_latency_txout", 32'(tx_b), 32'd0);
    @(negedge Clk);
    data_b = 4'hF;
    valid_b = 1'b1;
    repeat (3) @(negedge Clk);
    valid_b = 1'b0;
    repeat (20) @(negedge Clk);
    chk("b_frame_count", 32'(frames_b), 32'd1);
    chk("b_queue_empty", 32'(exp_b.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
